// File: rtl/pll_reset_seq.sv
// HDMI PLL bring-up sequencer: pulses the PLL reset, qualifies lock, then releases
// the pixel-clock divider and the TMDS serializers in order. Retries on lock timeout.
module pll_reset_seq #(
   parameter int unsigned PLL_RST_CYCLES     = 16,
   parameter int unsigned LOCK_TIMEOUT       = 270000,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned DIV_WAIT_CYCLES    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pll_lock,
   input  logic       force_restart,
   output logic       pll_reset,
   output logic       clkdiv_reset,
   output logic       serdes_reset,
   output logic       video_ready,
   output logic       lock_lost,
   output logic [3:0] retry_count,
   output logic [2:0] state
);

   localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned MAX_CD  = (LOCK_STABLE_CYCLES > DIV_WAIT_CYCLES) ? LOCK_STABLE_CYCLES
                                                                             : DIV_WAIT_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(DIV_WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_PLLRST   = 3'd0,
      ST_WAITLOCK = 3'd1,
      ST_STABLE   = 3'd2,
      ST_DIVREL   = 3'd3,
      ST_RUN      = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       retry_q, retry_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             pll_reset_q, pll_reset_d;
   logic             clkdiv_reset_q, clkdiv_reset_d;
   logic             serdes_reset_q, serdes_reset_d;
   logic             video_ready_q, video_ready_d;
   logic             lock_lost_q, lock_lost_d;
   logic             lock_s;

   assign lock_s = sync2_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      sync1_d = pll_lock;
      sync2_d = sync1_q;
      lock_lost_d = 1'b0;

      if (force_restart) begin
         state_d = ST_PLLRST;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_PLLRST: begin
               if (cnt_q == RST_LAST) begin
                  state_d = ST_WAITLOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_WAITLOCK: begin
               if (lock_s) begin
                  state_d = ST_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == TMO_LAST) begin
                  state_d = ST_PLLRST;
                  cnt_d   = '0;
                  retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_STABLE: begin
               if (!lock_s) begin
                  state_d = ST_WAITLOCK;
                  cnt_d   = '0;
               end else if (cnt_q == STABLE_LAST) begin
                  state_d = ST_DIVREL;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_DIVREL: begin
               if (cnt_q == DIV_LAST) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state_d     = ST_PLLRST;
                  cnt_d       = '0;
                  lock_lost_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_PLLRST;
               cnt_d   = '0;
            end
         endcase
      end

      // Outputs decode the next state so they update on the same edge as state.
      pll_reset_d    = (state_d == ST_PLLRST);
      clkdiv_reset_d = (state_d == ST_PLLRST) || (state_d == ST_WAITLOCK) || (state_d == ST_STABLE);
      serdes_reset_d = (state_d != ST_RUN);
      video_ready_d  = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_PLLRST;
         cnt_q          <= '0;
         retry_q        <= '0;
         sync1_q        <= 1'b0;
         sync2_q        <= 1'b0;
         pll_reset_q    <= 1'b1;
         clkdiv_reset_q <= 1'b1;
         serdes_reset_q <= 1'b1;
         video_ready_q  <= 1'b0;
         lock_lost_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         retry_q        <= retry_d;
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         pll_reset_q    <= pll_reset_d;
         clkdiv_reset_q <= clkdiv_reset_d;
         serdes_reset_q <= serdes_reset_d;
         video_ready_q  <= video_ready_d;
         lock_lost_q    <= lock_lost_d;
      end
   end

   assign pll_reset    = pll_reset_q;
   assign clkdiv_reset = clkdiv_reset_q;
   assign serdes_reset = serdes_reset_q;
   assign video_ready  = video_ready_q;
   assign lock_lost    = lock_lost_q;
   assign retry_count  = retry_q;
   assign state        = state_q;

endmodule
